alu_issue: RTL and testbench

Decode-to-execute issue stage on the driving side of the ALU operand interface. It accepts one decoded RV32I instruction per cycle, computes the ALU A operand, B operand and 4-bit ALUOp code, and presents them registered to the execute stage through a valid/ready handshake. A one-entry skid buffer lets a stalled execute stage back-pressure decode without losing an instruction. A flush input kills everything in flight.

---
 rtl/alu_issue.sv | 174 +++++++++++++++++
 tb/tb_alu_issue.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// Issue stage: decodes RV32I fields into ALU operands/op code and hands them to execute
// through a registered valid/ready output backed by a one-entry skid buffer.
module alu_issue (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        funct7_5,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [31:0] imm,
   input  logic [31:0] pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_op,
   output logic        illegal
);

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_SLL  = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SRL  = 4'd5;
   localparam logic [3:0] OP_SRA  = 4'd6;
   localparam logic [3:0] OP_OR   = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_LUI  = 4'd9;
   localparam logic [3:0] OP_SLT  = 4'd11;
   localparam logic [3:0] OP_SLTU = 4'd13;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic        illegal;
   } issue_t;

   issue_t      dec;
   logic [31:0] alu_src2;
   logic        accept;

   issue_t out_q, out_d;
   issue_t skid_q, skid_d;
   logic   out_valid_q, out_valid_d;
   logic   skid_valid_q, skid_valid_d;

   // Combinational decode of the presented instruction.
   always_comb begin
      dec      = '0;
      alu_src2 = (opcode == OPC_OP) ? rs2_data : imm;
      case (opcode)
         OPC_OP, OPC_OP_IMM: begin
            dec.a = rs1_data;
            dec.b = alu_src2;
            case (funct3)
               3'b000: dec.op = (opcode == OPC_OP && funct7_5) ? OP_SUB : OP_ADD;
               3'b001: begin
                  dec.op = OP_SLL;
                  dec.b  = {27'b0, alu_src2[4:0]};
               end
               3'b010: dec.op = OP_SLT;
               3'b011: dec.op = OP_SLTU;
               3'b100: dec.op = OP_XOR;
               3'b101: begin
                  dec.op = funct7_5 ? OP_SRA : OP_SRL;
                  dec.b  = {27'b0, alu_src2[4:0]};
               end
               3'b110: dec.op = OP_OR;
               default: dec.op = OP_AND;
            endcase
         end
         OPC_LUI: begin
            dec.b  = imm;
            dec.op = OP_LUI;
         end
         // The ALU's own auipc code is unused; the shift is done here instead.
         OPC_AUIPC: begin
            dec.a  = pc;
            dec.b  = {imm[19:0], 12'b0};
            dec.op = OP_ADD;
         end
         OPC_LOAD, OPC_STORE: begin
            dec.a  = rs1_data;
            dec.b  = imm;
            dec.op = OP_ADD;
         end
         OPC_BRANCH: begin
            case (funct3)
               3'b000, 3'b001: begin
                  dec.a  = rs1_data;
                  dec.b  = rs2_data;
                  dec.op = OP_SUB;
               end
               3'b100, 3'b101: begin
                  dec.a  = rs1_data;
                  dec.b  = rs2_data;
                  dec.op = OP_SLT;
               end
               3'b110, 3'b111: begin
                  dec.a  = rs1_data;
                  dec.b  = rs2_data;
                  dec.op = OP_SLTU;
               end
               default: dec.illegal = 1'b1;
            endcase
         end
         default: dec.illegal = 1'b1;
      endcase
   end

   assign in_ready = !skid_valid_q && !rst && !flush;
   assign accept   = in_valid && in_ready;

   // Skid entry has priority when the output frees up, preserving acceptance order.
   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_ready) begin
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign alu_a     = out_q.a;
   assign alu_b     = out_q.b;
   assign alu_op    = out_q.op;
   assign illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus a randomized run
// against a two-slot in-order FIFO reference with a behavioural decoder.
module tb_alu_issue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic        funct7_5 = 1'b0;
   logic [31:0] rs1_data = '0;
   logic [31:0] rs2_data = '0;
   logic [31:0] imm = '0;
   logic [31:0] pc = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_op;
   logic        illegal;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
      logic        ill;
   } exp_t;

   exp_t q[$];
   exp_t last_out = '0;

   alu_issue dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .rs1_data(rs1_data),
      .rs2_data(rs2_data), .imm(imm), .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // Behavioural decoder written straight from the instruction rules.
   function automatic exp_t ref_decode(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                       input logic [31:0] r1, input logic [31:0] r2,
                                       input logic [31:0] im, input logic [31:0] p);
      exp_t e;
      logic [31:0] src;
      e = '0;
      if (o == 7'h33 || o == 7'h13) begin
         src = (o == 7'h33) ? r2 : im;
         e.a = r1;
         e.b = src;
         case (f3)
            3'd0: e.op = (o == 7'h33 && f7) ? 4'd2 : 4'd1;
            3'd1: begin e.op = 4'd3; e.b = src % 32; end
            3'd2: e.op = 4'd11;
            3'd3: e.op = 4'd13;
            3'd4: e.op = 4'd4;
            3'd5: begin e.op = f7 ? 4'd6 : 4'd5; e.b = src % 32; end
            3'd6: e.op = 4'd7;
            default: e.op = 4'd8;
         endcase
      end else if (o == 7'h37) begin
         e.b = im; e.op = 4'd9;
      end else if (o == 7'h17) begin
         e.a = p; e.b = im * 32'd4096; e.op = 4'd1;
      end else if (o == 7'h03 || o == 7'h23) begin
         e.a = r1; e.b = im; e.op = 4'd1;
      end else if (o == 7'h63 && f3 != 3'd2 && f3 != 3'd3) begin
         e.a = r1; e.b = r2;
         e.op = (f3 < 3'd2) ? 4'd2 : (f3 < 3'd6) ? 4'd11 : 4'd13;
      end else begin
         e.ill = 1'b1;
      end
      return e;
   endfunction

   task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                        input logic [31:0] p);
      in_valid = v; opcode = o; funct3 = f3; funct7_5 = f7;
      rs1_data = r1; rs2_data = r2; imm = im; pc = p;
   endtask

   // Advance one clock and update the reference: an in-order queue of at most two entries.
   task automatic step();
      exp_t e;
      bit   pop;
      bit   push;
      @(posedge clk);
      e    = ref_decode(opcode, funct3, funct7_5, rs1_data, rs2_data, imm, pc);
      pop  = (q.size() > 0) && out_ready;
      push = in_valid && (q.size() < 2);
      if (rst) begin
         q.delete();
         last_out = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back(e);
      end
      if (q.size() > 0) last_out = q[0];
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; out_ready = 1'b1;
      drive(1'b1, 7'h33, 3'd0, 1'b0, 32'h5, 32'h6, 32'h7, 32'h8);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready_pre: got %b want 0", in_ready); end
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
         checks++; if ({out_valid, alu_a, alu_b, alu_op, illegal} !== 70'd0) begin
            failures++; $display("FAIL reset_outputs: got v=%b a=%h b=%h op=%0d ill=%b want all 0", out_valid, alu_a, alu_b, alu_op, illegal);
         end
      end
      rst = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle_valid: got %b want 0", out_valid); end
   endtask

   task automatic test_stream();
      logic [3:0] want_op[3] = '{4'd1, 4'd2, 4'd6};
      logic [2:0] f3s[3]     = '{3'd0, 3'd0, 3'd5};
      logic       f7s[3]     = '{1'b0, 1'b1, 1'b1};
      logic [31:0] want_b[3] = '{32'h24, 32'h24, 32'h4};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 7'h33, f3s[i], f7s[i], 32'h8000_0010, 32'h0000_0024, 32'h0, 32'h0);
         step();
         checks++; if ({out_valid, alu_a, alu_b, alu_op} !== {1'b1, 32'h8000_0010, want_b[i], want_op[i]}) begin
            failures++; $display("FAIL stream_%0d: got v=%b a=%h b=%h op=%0d want v=1 a=80000010 b=%h op=%0d", i, out_valid, alu_a, alu_b, alu_op, want_b[i], want_op[i]);
         end
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_lui_auipc();
      out_ready = 1'b1;
      drive(1'b1, 7'h37, 3'd0, 1'b0, 32'hdead_beef, 32'h0, 32'h0001_2345, 32'h0);
      step();
      checks++; if ({out_valid, alu_a, alu_b, alu_op} !== {1'b1, 32'h0, 32'h0001_2345, 4'd9}) begin
         failures++; $display("FAIL lui: got v=%b a=%h b=%h op=%0d want v=1 a=0 b=12345 op=9", out_valid, alu_a, alu_b, alu_op);
      end
      drive(1'b1, 7'h17, 3'd0, 1'b0, 32'hdead_beef, 32'h0, 32'h1, 32'h100);
      step();
      checks++; if ({out_valid, alu_a, alu_b, alu_op} !== {1'b1, 32'h100, 32'h1000, 4'd1}) begin
         failures++; $display("FAIL auipc: got v=%b a=%h b=%h op=%0d want v=1 a=100 b=1000 op=1", out_valid, alu_a, alu_b, alu_op);
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_back_pressure();
      out_ready = 1'b0;
      drive(1'b1, 7'h13, 3'd0, 1'b0, 32'h11, 32'h0, 32'h1, 32'h0);    // I0 addi
      step();
      checks++; if ({out_valid, alu_a, in_ready} !== {1'b1, 32'h11, 1'b1}) begin
         failures++; $display("FAIL bp_i0: got v=%b a=%h rdy=%b want v=1 a=11 rdy=1", out_valid, alu_a, in_ready);
      end
      drive(1'b1, 7'h13, 3'd4, 1'b0, 32'h22, 32'h0, 32'hff, 32'h0);   // I1 xori
      step();
      checks++; if ({out_valid, alu_a, alu_op, in_ready} !== {1'b1, 32'h11, 4'd1, 1'b0}) begin
         failures++; $display("FAIL bp_full: got v=%b a=%h op=%0d rdy=%b want v=1 a=11 op=1 rdy=0", out_valid, alu_a, alu_op, in_ready);
      end
      drive(1'b1, 7'h33, 3'd7, 1'b0, 32'h33, 32'h0f, 32'h0, 32'h0);   // I2 and
      step();
      checks++; if ({out_valid, alu_a, alu_b, in_ready} !== {1'b1, 32'h11, 32'h1, 1'b0}) begin
         failures++; $display("FAIL bp_hold: got v=%b a=%h b=%h rdy=%b want v=1 a=11 b=1 rdy=0", out_valid, alu_a, alu_b, in_ready);
      end
      out_ready = 1'b1;
      step();
      checks++; if ({out_valid, alu_a, alu_b, alu_op, in_ready} !== {1'b1, 32'h22, 32'hff, 4'd4, 1'b1}) begin
         failures++; $display("FAIL bp_i1: got v=%b a=%h b=%h op=%0d rdy=%b want v=1 a=22 b=ff op=4 rdy=1", out_valid, alu_a, alu_b, alu_op, in_ready);
      end
      step();
      checks++; if ({out_valid, alu_a, alu_b, alu_op} !== {1'b1, 32'h33, 32'h0f, 4'd8}) begin
         failures++; $display("FAIL bp_i2: got v=%b a=%h b=%h op=%0d want v=1 a=33 b=f op=8", out_valid, alu_a, alu_b, alu_op);
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 7'h13, 3'd0, 1'b0, 32'h44, 32'h0, 32'h2, 32'h0);
      step();
      drive(1'b1, 7'h13, 3'd6, 1'b0, 32'h55, 32'h0, 32'h3, 32'h0);
      step();
      flush = 1'b1;
      drive(1'b1, 7'h33, 3'd0, 1'b0, 32'h66, 32'h7, 32'h0, 32'h0);
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
      step();
      checks++; if ({out_valid, alu_a, alu_b} !== {1'b0, 32'h44, 32'h2}) begin
         failures++; $display("FAIL flush_clear: got v=%b a=%h b=%h want v=0 a=44 b=2", out_valid, alu_a, alu_b);
      end
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++; if ({out_valid, in_ready} !== 2'b01) begin
            failures++; $display("FAIL flush_after_%0d: got v=%b rdy=%b want v=0 rdy=1", i, out_valid, in_ready);
         end
      end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      drive(1'b1, 7'h73, 3'd0, 1'b0, 32'h77, 32'h88, 32'h99, 32'haa);
      step();
      checks++; if ({out_valid, illegal, alu_op, alu_a, alu_b} !== {1'b1, 1'b1, 4'd0, 32'h0, 32'h0}) begin
         failures++; $display("FAIL illegal_opc: got v=%b ill=%b op=%0d a=%h b=%h want v=1 ill=1 op=0 a=0 b=0", out_valid, illegal, alu_op, alu_a, alu_b);
      end
      drive(1'b1, 7'h63, 3'd2, 1'b0, 32'h77, 32'h88, 32'h99, 32'haa);
      step();
      checks++; if ({out_valid, illegal, alu_op} !== {1'b1, 1'b1, 4'd0}) begin
         failures++; $display("FAIL illegal_branch: got v=%b ill=%b op=%0d want v=1 ill=1 op=0", out_valid, illegal, alu_op);
      end
      drive(1'b1, 7'h63, 3'd6, 1'b0, 32'h77, 32'h88, 32'h0, 32'h0);
      step();
      checks++; if ({out_valid, illegal, alu_op, alu_a, alu_b} !== {1'b1, 1'b0, 4'd13, 32'h77, 32'h88}) begin
         failures++; $display("FAIL branch_bltu: got v=%b ill=%b op=%0d a=%h b=%h want v=1 ill=0 op=13 a=77 b=88", out_valid, illegal, alu_op, alu_a, alu_b);
      end
      in_valid = 1'b0;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL illegal_drain: got %b want 0", out_valid); end
   endtask

   task automatic test_random();
      logic [6:0] opcs[8] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h00};
      logic [6:0] o;
      exp_t       e;
      for (int i = 0; i < 600; i++) begin
         o = opcs[$urandom_range(0, 7)];
         if (o == 7'h00) o = 7'($urandom);
         drive($urandom_range(0, 3) != 0, o, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom, $urandom);
         flush     = ($urandom_range(0, 49) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         e = (q.size() > 0) ? q[0] : last_out;
         checks++; if (out_valid !== (q.size() > 0)) begin
            failures++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, q.size() > 0);
         end
         checks++; if (in_ready !== (!flush && q.size() < 2)) begin
            failures++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, !flush && q.size() < 2);
         end
         checks++; if ({alu_a, alu_b, alu_op, illegal} !== e) begin
            failures++; $display("FAIL rand_data[%0d]: got a=%h b=%h op=%0d ill=%b want a=%h b=%h op=%0d ill=%b", i, alu_a, alu_b, alu_op, illegal, e.a, e.b, e.op, e.ill);
         end
         step();
      end
      flush = 1'b0; in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_lui_auipc();
      test_back_pressure();
      test_flush();
      test_illegal();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
